mem_access_sequencer: RTL
=========================

// Module: mem_access_sequencer
// PURPOSE
//  Clocked successor to the combinational memory-op decoder. Decodes ARM addressing-mode-2/3
//  load/store from IR and runs the MFA/MOC bus handshake, including two-beat LDRD/STRD.
//  Performs load zero/sign extension, a wait timeout and optional alignment faults.
//  Sits between the control unit (start/done) and the memory interface.
// PARAMETERS
//  ADDR_W   32   memory address width; beat-2 address = beat-1 address + 4, mod 2^ADDR_W
//  TIMEOUT  255  max cycles MFA may stay high without MOC before fault; 0 = no timeout
//  TO_W     8    timeout counter width; must satisfy TIMEOUT < 2^TO_W
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high
//  start      in   1       begin operation; sampled in IDLE only
//  ir         in   32      instruction register
//  addr       in   ADDR_W  effective address
//  wdata_lo   in   32      store data, beat 1 (right-justified)
//  wdata_hi   in   32      store data, beat 2 (STRD)
//  busy       out  1       high from cycle after start until done
//  done       out  1       1-cycle completion pulse
//  fault      out  1       held from done until next accepted start
//  rdata_lo   out  32      load result, beat 1 (extended); held until next start
//  rdata_hi   out  32      load result, beat 2 (LDRD)
//  mfa        out  1       memory function active
//  mem_rw     out  1       1 = read, 0 = write
//  mem_size   out  2       00 byte, 01 half, 10 word
//  mem_addr   out  ADDR_W  bus address
//  mem_wdata  out  32      bus write data
//  mem_rdata  in   32      bus read data, right-justified
//  moc        in   1       memory operation complete
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, immediate even mid-transfer (mfa drops asynchronously).
//  Decode at start; ir, addr and wdata are latched.
//  - ir[27:26]=01 (mode 2): L=ir[20]; size=ir[22]?byte:word; zero-extended.
//  - ir[27:25]=000, ir[7]=ir[4]=1, ir[6:5]!=00 (mode 3):
//      L=1: 01 LDRH zext, 10 LDRSB sext, 11 LDRSH sext.
//      L=0: 01 STRH, 10 LDRD, 11 STRD (word, two beats).
//  - Anything else is illegal: fault=1 and done one cycle after start, with no bus cycle.
//  FSM: IDLE -> REQ1 -> GAP -> REQ2 -> FIN -> IDLE. Single-beat ops skip GAP and REQ2.
//  REQ*: mfa=1; mem_addr, mem_rw, mem_size and mem_wdata stay stable until moc is sampled 1.
//   On the moc cycle, read data is captured (extended) into rdata_lo or rdata_hi.
//  GAP: mfa=0 for exactly one cycle between beats.
//  FIN: done=1 for one cycle, busy=0; same-cycle start is ignored (accepted next cycle).
//  Minimum latency with moc returned the first cycle REQ is active:
//   single beat: done 3 cycles after start; double beat: 5 cycles.
//  Timeout: the counter clears on each REQ entry and increments while mfa=1 and moc=0.
//   At count==TIMEOUT it aborts to FIN with fault=1; rdata keeps the beats already captured.
//  start while busy: ignored. moc outside REQ: ignored.
//  Stores leave rdata unchanged; fault clears on the accepted start.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: half with addr[0]=1, or word/dual with addr[1:0]!=0,
//   gives fault=1 with done one cycle after start and no bus cycle.
//  Not defined: addresses are issued unmodified and no alignment fault exists.
// TESTING
//  LDR ir=E5912000, addr=100, moc on 1st REQ cycle, rdata=DEADBEEF -> mem_size=10,
//   rdata_lo=DEADBEEF, done 3 cycles after start, fault=0.
//  LDRSB (mode3 L=1, 6:5=10), rdata=00000080 -> rdata_lo=FFFFFF80.
//   Same with LDRH -> rdata_lo=00000080.
//  STRD addr=FFFFFFFC, ADDR_W=32 -> beat1 FFFFFFFC/wdata_lo, 1 GAP cycle with mfa=0,
//   beat2 00000000/wdata_hi; done at 5 cycles.
//  TIMEOUT=4, moc held 0 -> mfa high exactly 4 cycles, then fault=1, done pulse, busy=0.
//  ir=E0812003 (data-processing) -> fault=1, done next cycle, mfa never asserted.
//  reset asserted during REQ2 of LDRD -> mfa/busy/done=0 immediately; start after release works.
//  ALIGN_CHECK_EN, LDRH addr=101 -> fault with no bus cycle; without the macro -> mem_addr=101.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Clocked ARM addressing-mode-2/3 load/store sequencer driving an MFA/MOC memory bus.
// Optional feature: define ALIGN_CHECK_EN to fault misaligned half/word/dual accesses.
module mem_access_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       ir,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata_lo,
  input  logic [31:0]       wdata_hi,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata_lo,
  output logic [31:0]       rdata_hi,
  output logic              mfa,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              moc,
  output logic [2:0]        dbg_state
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ1  = 3'd2,
    GAP   = 3'd3,
    REQ2  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t            state_q;
  logic              busy_q, done_q, fault_q, mfa_q, rw_q, dual_q, sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, whi_q, rdata_lo_q, rdata_hi_q;
  logic [TO_W-1:0]   cnt_q;

  logic       mode2, mode3, legal, dec_read, dec_dual, dec_sext, misalign;
  logic [1:0] dec_size;
  logic       unused_ir;

  assign unused_ir = ^{ir[31:28], ir[24:23], ir[21], ir[19:8], ir[3:0]};

  always_comb begin
    mode2    = (ir[27:26] == 2'b01);
    mode3    = (ir[27:25] == 3'b000) && ir[7] && ir[4] && (ir[6:5] != 2'b00);
    legal    = mode2 || mode3;
    dec_read = 1'b0;
    dec_dual = 1'b0;
    dec_sext = 1'b0;
    dec_size = SZ_W;
    if (mode2) begin
      dec_read = ir[20];
      dec_size = ir[22] ? SZ_B : SZ_W;
    end else if (mode3) begin
      if (ir[20]) begin
        dec_read = 1'b1;
        dec_size = (ir[6:5] == 2'b10) ? SZ_B : SZ_H;
        dec_sext = ir[6];
      end else begin
        // With L=0 the sh field encodes STRH, LDRD (10) and STRD (11).
        dec_size = (ir[6:5] == 2'b01) ? SZ_H : SZ_W;
        dec_dual = ir[6];
        dec_read = (ir[6:5] == 2'b10);
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  assign misalign = ((dec_size == SZ_H) && addr[0]) ||
                    ((dec_size == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  logic [TO_W-1:0] cnt_d;
  logic            to_hit;
  assign cnt_d  = cnt_q + 1'b1;
  assign to_hit = (TIMEOUT != 0) && (cnt_d == TO_W'(TIMEOUT));

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic sx);
    case (sz)
      SZ_B:    extend = {{24{sx & d[7]}}, d[7:0]};
      SZ_H:    extend = {{16{sx & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Bus handshake: mfa rises with addr/rw/size/wdata already stable; they hold until a rising
  // edge samples moc=1, which completes the beat, captures read data and drops mfa.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      mfa_q       <= 1'b0;
      rw_q        <= 1'b0;
      dual_q      <= 1'b0;
      sext_q      <= 1'b0;
      size_q      <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      whi_q       <= '0;
      rdata_lo_q  <= '0;
      rdata_hi_q  <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!legal || misalign) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q     <= SETUP;
              busy_q      <= 1'b1;
              fault_q     <= 1'b0;
              rw_q        <= dec_read;
              dual_q      <= dec_dual;
              sext_q      <= dec_sext;
              size_q      <= dec_size;
              mem_addr_q  <= addr;
              mem_wdata_q <= dec_read ? 32'd0 : wdata_lo;
              whi_q       <= wdata_hi;
            end
          end
        end
        SETUP, GAP: begin
          state_q <= (state_q == SETUP) ? REQ1 : REQ2;
          mfa_q   <= 1'b1;
          cnt_q   <= '0;
        end
        REQ1, REQ2: begin
          if (moc) begin
            mfa_q <= 1'b0;
            if (rw_q && state_q == REQ1) rdata_lo_q <= extend(mem_rdata, size_q, sext_q);
            if (rw_q && state_q == REQ2) rdata_hi_q <= extend(mem_rdata, size_q, sext_q);
            if (state_q == REQ1 && dual_q) begin
              state_q    <= GAP;
              mem_addr_q <= mem_addr_q + ADDR_W'(4);
              if (!rw_q) mem_wdata_q <= whi_q;
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else if (to_hit) begin
            mfa_q   <= 1'b0;
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata_lo  = rdata_lo_q;
  assign rdata_hi  = rdata_hi_q;
  assign mfa       = mfa_q;
  assign mem_rw    = rw_q;
  assign mem_size  = size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule
